alu_ctrl: RTL and testbench

Execute-stage sequencer for the 16-bit ALU.
- Accepts one operation per request over a valid/ready handshake and drives the ALU operand inputs from registered operands.
- Selects the matching ALU result, updates a status flag register (Z,N,C,V) and presents the result to register-file writeback over a second valid/ready handshake.
- Adds a multi-cycle SHL operation by iterating the ALU adder (a+a) under a shift counter.

---
 rtl/alu_ctrl_pkg.sv | 27 ++
 rtl/alu_ctrl_flag_gen.sv | 42 ++++
 rtl/alu_ctrl.sv | 157 +++++++++++++++
 tb/tb_alu_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU execute-stage sequencer.
// Opcode encoding, FSM state codes and flag bit positions.
package alu_ctrl_pkg;

   localparam int unsigned DATA_W = 16;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_AND = 3'd2,
      OP_OR  = 3'd3,
      OP_XOR = 3'd4,
      OP_NOT = 3'd5,
      OP_CMP = 3'd6,
      OP_SHL = 3'd7
   } opcode_e;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_WB   = 2'd2;

   localparam int unsigned FLAG_Z = 3;
   localparam int unsigned FLAG_N = 2;
   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/alu_ctrl_flag_gen.sv
// Combinational next-flag generator: Z/N from the result, C/V per opcode,
// untouched flags carried through from the current flag register.
module alu_flag_gen
   import alu_ctrl_pkg::*;
#(
   parameter int unsigned DATA_W = 16
) (
   input  opcode_e           opcode_i,
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   input  logic [DATA_W-1:0] result_i,
   input  logic              carry_i,
   input  logic [3:0]        flags_i,
   output logic [3:0]        flags_o
);

   logic a_msb, b_msb, r_msb;

   assign a_msb = a_i[DATA_W-1];
   assign b_msb = b_i[DATA_W-1];
   assign r_msb = result_i[DATA_W-1];

   always_comb begin
      flags_o         = flags_i;
      flags_o[FLAG_Z] = (result_i == '0);
      flags_o[FLAG_N] = r_msb;
      unique case (opcode_i)
         OP_ADD: begin
            flags_o[FLAG_C] = carry_i;
            flags_o[FLAG_V] = (a_msb == b_msb) && (r_msb != a_msb);
         end
         // Carry means "no borrow" for subtraction.
         OP_SUB, OP_CMP: begin
            flags_o[FLAG_C] = carry_i;
            flags_o[FLAG_V] = (a_msb != b_msb) && (r_msb != a_msb);
         end
         OP_SHL: flags_o[FLAG_C] = carry_i;
         default: ;
      endcase
   end

endmodule

// File: rtl/alu_ctrl.sv
// Execute-stage sequencer for the 16-bit ALU: request handshake, operand
// registers, result select, flag register, writeback handshake and iterative SHL.
module alu_ctrl #(
   parameter int unsigned DATA_W  = alu_ctrl_pkg::DATA_W,
   parameter int unsigned RD_W    = 3,
   parameter int unsigned SHAMT_W = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [2:0]         req_opcode,
   input  logic [DATA_W-1:0]  req_a,
   input  logic [DATA_W-1:0]  req_b,
   input  logic [RD_W-1:0]    req_rd,
   input  logic [SHAMT_W-1:0] req_shamt,
   output logic [DATA_W-1:0]  alu_op1,
   output logic [DATA_W-1:0]  alu_op2,
   input  logic [DATA_W-1:0]  alu_add,
   input  logic [DATA_W-1:0]  alu_sub,
   input  logic [DATA_W-1:0]  alu_and,
   input  logic [DATA_W-1:0]  alu_or,
   input  logic [DATA_W-1:0]  alu_xor,
   input  logic [DATA_W-1:0]  alu_not,
   input  logic [DATA_W-1:0]  alu_cmp,
   input  logic               alu_carry,
   output logic               wb_valid,
   input  logic               wb_ready,
   output logic [DATA_W-1:0]  wb_data,
   output logic [RD_W-1:0]    wb_rd,
   output logic [3:0]         flags,
   output logic               busy
);
   import alu_ctrl_pkg::*;

   logic [1:0]         state_q, state_d;
   logic [DATA_W-1:0]  a_q, a_d;
   logic [DATA_W-1:0]  b_q, b_d;
   opcode_e            op_q, op_d;
   logic [RD_W-1:0]    rd_q, rd_d;
   logic [SHAMT_W-1:0] cnt_q, cnt_d;
   logic [3:0]         flags_q, flags_d, flags_nxt;
   logic [DATA_W-1:0]  wb_data_q, wb_data_d;
   logic [DATA_W-1:0]  result;
   logic               res_carry;
   logic               accept;

   assign req_ready = (state_q == ST_IDLE) && !reset;
   assign accept    = req_valid && req_ready;
   assign busy      = (state_q != ST_IDLE);
   assign wb_valid  = (state_q == ST_WB);
   assign wb_data   = wb_data_q;
   assign wb_rd     = rd_q;
   assign flags     = flags_q;

   // SHL doubles A through the adder, so both operands carry A.
   assign alu_op1 = a_q;
   assign alu_op2 = (op_q == OP_SHL) ? a_q : b_q;

   always_comb begin
      result    = alu_add;
      res_carry = alu_carry;
      unique case (op_q)
         OP_ADD: result = alu_add;
         OP_SUB: result = alu_sub;
         OP_AND: result = alu_and;
         OP_OR:  result = alu_or;
         OP_XOR: result = alu_xor;
         OP_NOT: result = alu_not;
         OP_CMP: result = alu_cmp;
         OP_SHL: begin
            if (cnt_q == '0) begin
               result    = a_q;
               res_carry = flags_q[FLAG_C];
            end else begin
               result = alu_add;
            end
         end
      endcase
   end

   alu_flag_gen #(
      .DATA_W (DATA_W)
   ) u_flag_gen (
      .opcode_i (op_q),
      .a_i      (a_q),
      .b_i      (b_q),
      .result_i (result),
      .carry_i  (res_carry),
      .flags_i  (flags_q),
      .flags_o  (flags_nxt)
   );

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      op_d      = op_q;
      rd_d      = rd_q;
      cnt_d     = cnt_q;
      flags_d   = flags_q;
      wb_data_d = wb_data_q;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               a_d     = req_a;
               b_d     = req_b;
               op_d    = opcode_e'(req_opcode);
               rd_d    = req_rd;
               cnt_d   = req_shamt;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if ((op_q == OP_SHL) && (cnt_q > SHAMT_W'(1))) begin
               a_d   = alu_add;
               cnt_d = cnt_q - SHAMT_W'(1);
            end else begin
               flags_d = flags_nxt;
               if (op_q == OP_CMP) begin
                  state_d = ST_IDLE;
               end else begin
                  wb_data_d = result;
                  state_d   = ST_WB;
               end
            end
         end
         ST_WB: begin
            if (wb_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         a_q       <= '0;
         b_q       <= '0;
         op_q      <= OP_ADD;
         rd_q      <= '0;
         cnt_q     <= '0;
         flags_q   <= '0;
         wb_data_q <= '0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         op_q      <= op_d;
         rd_q      <= rd_d;
         cnt_q     <= cnt_d;
         flags_q   <= flags_d;
         wb_data_q <= wb_data_d;
      end
   end

endmodule

// File: tb/tb_alu_ctrl.sv
// Bench for alu_ctrl: behavioural ALU, directed vector table, mid-operation
// reset sequence and randomized ops checked against an arithmetic reference model.
module tb_alu_ctrl;
   import alu_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready;
   logic [2:0]  req_opcode;
   logic [15:0] req_a, req_b;
   logic [2:0]  req_rd;
   logic [3:0]  req_shamt;
   logic [15:0] alu_op1, alu_op2;
   logic [15:0] alu_add, alu_sub, alu_and, alu_or, alu_xor, alu_not, alu_cmp;
   logic        alu_carry;
   logic        wb_valid, wb_ready;
   logic [15:0] wb_data;
   logic [2:0]  wb_rd;
   logic [3:0]  flags;
   logic        busy;

   logic [2:0]  cur_op;
   logic [16:0] sum17;
   logic [3:0]  mflags;
   int          n_vec = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   alu_ctrl #(
      .DATA_W  (16),
      .RD_W    (3),
      .SHAMT_W (4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_opcode (req_opcode),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_rd     (req_rd),
      .req_shamt  (req_shamt),
      .alu_op1    (alu_op1),
      .alu_op2    (alu_op2),
      .alu_add    (alu_add),
      .alu_sub    (alu_sub),
      .alu_and    (alu_and),
      .alu_or     (alu_or),
      .alu_xor    (alu_xor),
      .alu_not    (alu_not),
      .alu_cmp    (alu_cmp),
      .alu_carry  (alu_carry),
      .wb_valid   (wb_valid),
      .wb_ready   (wb_ready),
      .wb_data    (wb_data),
      .wb_rd      (wb_rd),
      .flags      (flags),
      .busy       (busy)
   );

   // External ALU: carry reflects subtraction (no borrow) for SUB/CMP, else add carry-out.
   assign sum17     = {1'b0, alu_op1} + {1'b0, alu_op2};
   assign alu_add   = sum17[15:0];
   assign alu_sub   = alu_op1 - alu_op2;
   assign alu_and   = alu_op1 & alu_op2;
   assign alu_or    = alu_op1 | alu_op2;
   assign alu_xor   = alu_op1 ^ alu_op2;
   assign alu_not   = ~alu_op1;
   assign alu_cmp   = alu_op1 - alu_op2;
   assign alu_carry = (cur_op == OP_SUB || cur_op == OP_CMP) ? (alu_op1 >= alu_op2) : sum17[16];

   typedef struct {
      logic [2:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [2:0]  rd;
      logic [3:0]  sh;
      int          hold;
      logic [15:0] xd;
      logic [3:0]  xf;
   } vec_t;

   vec_t tbl[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Returns {result, Z, N, C, V} from plain integer arithmetic.
   function automatic logic [19:0] model(input logic [2:0] op, input logic [15:0] a,
                                         input logic [15:0] b, input logic [3:0] sh,
                                         input logic [3:0] fin);
      logic [15:0] r;
      logic        c, v;
      int          sa, sb, s;
      logic [31:0] w;
      c  = fin[1];
      v  = fin[0];
      sa = int'($signed(a));
      sb = int'($signed(b));
      r  = '0;
      case (op)
         3'd0: begin
            r = a + b;
            c = (int'(a) + int'(b)) > 65535;
            s = sa + sb;
            v = (s > 32767) || (s < -32768);
         end
         3'd1, 3'd6: begin
            r = a - b;
            c = (a >= b);
            s = sa - sb;
            v = (s > 32767) || (s < -32768);
         end
         3'd2: r = a & b;
         3'd3: r = a | b;
         3'd4: r = a ^ b;
         3'd5: r = ~a;
         default: begin
            w = {16'h0000, a} << sh;
            r = w[15:0];
            if (sh != 4'd0) c = w[16];
         end
      endcase
      return {r, (r == 16'h0000), r[15], c, v};
   endfunction

   task automatic do_op(input int id, input logic [2:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [2:0] rd, input logic [3:0] sh,
                        input int hold, input logic [15:0] xd, input logic [3:0] xf);
      int lat;
      lat = (op == OP_SHL) ? 1 + ((sh == 4'd0) ? 1 : int'(sh)) : 2;
      check($sformatf("v%0d req_ready_idle", id), req_ready, 1);
      cur_op     = op;
      req_opcode = op;
      req_a      = a;
      req_b      = b;
      req_rd     = rd;
      req_shamt  = sh;
      req_valid  = 1'b1;
      wb_ready   = 1'b0;
      for (int cyc = 1; cyc < lat; cyc++) begin
         @(posedge clk);
         #1;
         req_valid = 1'b0;
         req_a     = 16'($urandom);
         req_b     = 16'($urandom);
         check($sformatf("v%0d exec%0d busy", id, cyc), busy, 1);
         check($sformatf("v%0d exec%0d wb_valid", id, cyc), wb_valid, 0);
      end
      @(posedge clk);
      #1;
      if (op == OP_CMP) begin
         check($sformatf("v%0d cmp wb_valid", id), wb_valid, 0);
         check($sformatf("v%0d cmp req_ready", id), req_ready, 1);
         check($sformatf("v%0d cmp flags", id), flags, xf);
      end else begin
         check($sformatf("v%0d wb_valid", id), wb_valid, 1);
         check($sformatf("v%0d wb_data", id), wb_data, xd);
         check($sformatf("v%0d wb_rd", id), wb_rd, rd);
         check($sformatf("v%0d flags", id), flags, xf);
         for (int h = 0; h < hold; h++) begin
            if (h == 0) begin
               req_valid  = 1'b1;
               req_opcode = OP_ADD;
            end
            @(posedge clk);
            #1;
            check($sformatf("v%0d hold%0d wb_valid", id, h), wb_valid, 1);
            check($sformatf("v%0d hold%0d wb_data", id, h), wb_data, xd);
            check($sformatf("v%0d hold%0d req_ready", id, h), req_ready, 0);
         end
         wb_ready = 1'b1;
         @(posedge clk);
         #1;
         wb_ready  = 1'b0;
         req_valid = 1'b0;
         check($sformatf("v%0d post wb_valid", id), wb_valid, 0);
         check($sformatf("v%0d post busy", id), busy, 0);
      end
      mflags = xf;
   endtask

   initial begin
      logic [19:0] exp;
      logic [2:0]  op;
      logic [15:0] a, b;
      logic [3:0]  sh;
      logic        seen_wb;

      tbl[0]  = '{OP_ADD, 16'h7FFF, 16'h0001, 3'd3, 4'd0, 0, 16'h8000, 4'b0101};
      tbl[1]  = '{OP_SUB, 16'h0005, 16'h0005, 3'd1, 4'd0, 0, 16'h0000, 4'b1010};
      tbl[2]  = '{OP_CMP, 16'h0003, 16'h0004, 3'd2, 4'd0, 0, 16'h0000, 4'b0100};
      tbl[3]  = '{OP_SHL, 16'h4001, 16'h0000, 3'd5, 4'd2, 0, 16'h0004, 4'b0010};
      tbl[4]  = '{OP_AND, 16'hF0F0, 16'h0FF0, 3'd6, 4'd0, 5, 16'h00F0, 4'b0010};
      tbl[5]  = '{OP_XOR, 16'hFFFF, 16'hFFFF, 3'd7, 4'd0, 0, 16'h0000, 4'b1010};
      tbl[6]  = '{OP_NOT, 16'h0000, 16'h1234, 3'd0, 4'd0, 1, 16'hFFFF, 4'b0110};
      tbl[7]  = '{OP_OR,  16'h8000, 16'h0001, 3'd4, 4'd0, 0, 16'h8001, 4'b0110};
      tbl[8]  = '{OP_SHL, 16'h1234, 16'hFFFF, 3'd2, 4'd0, 0, 16'h1234, 4'b0010};
      tbl[9]  = '{OP_ADD, 16'hFFFF, 16'h0001, 3'd1, 4'd0, 2, 16'h0000, 4'b1010};
      tbl[10] = '{OP_SUB, 16'h8000, 16'h0001, 3'd3, 4'd0, 0, 16'h7FFF, 4'b0011};
      tbl[11] = '{OP_SHL, 16'h8000, 16'h0000, 3'd5, 4'd15, 0, 16'h0000, 4'b1001};

      reset      = 1'b1;
      req_valid  = 1'b0;
      req_opcode = 3'd0;
      req_a      = '0;
      req_b      = '0;
      req_rd     = '0;
      req_shamt  = '0;
      wb_ready   = 1'b0;
      cur_op     = 3'd0;
      mflags     = 4'b0000;

      repeat (3) @(posedge clk);
      #1;
      check("reset req_ready", req_ready, 0);
      reset = 1'b0;
      #1;
      check("reset busy", busy, 0);
      check("reset wb_valid", wb_valid, 0);
      check("reset wb_data", wb_data, 0);
      check("reset wb_rd", wb_rd, 0);
      check("reset flags", flags, 0);
      check("reset alu_op1", alu_op1, 0);
      check("reset alu_op2", alu_op2, 0);
      check("reset req_ready_after", req_ready, 1);

      for (int i = 0; i < 12; i++) begin
         do_op(i, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].rd, tbl[i].sh, tbl[i].hold,
               tbl[i].xd, tbl[i].xf);
      end

      // Reset lands on the 4th EXEC cycle of a long shift.
      check("rst_seq req_ready", req_ready, 1);
      cur_op     = OP_SHL;
      req_opcode = OP_SHL;
      req_a      = 16'h1357;
      req_shamt  = 4'd15;
      req_rd     = 3'd6;
      req_valid  = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      check("rst_seq busy_before", busy, 1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("rst_seq busy", busy, 0);
      check("rst_seq flags", flags, 0);
      check("rst_seq wb_valid", wb_valid, 0);
      check("rst_seq req_ready_in_reset", req_ready, 0);
      check("rst_seq wb_data", wb_data, 0);
      reset = 1'b0;
      #1;
      check("rst_seq req_ready", req_ready, 1);
      seen_wb = 1'b0;
      repeat (20) begin
         @(posedge clk);
         #1;
         seen_wb = seen_wb | wb_valid;
      end
      check("rst_seq no_writeback", seen_wb, 0);
      mflags = 4'b0000;

      for (int i = 0; i < 200; i++) begin
         op = 3'($urandom_range(0, 7));
         a  = 16'($urandom);
         b  = 16'($urandom);
         case ($urandom_range(0, 7))
            0: a = 16'h7FFF;
            1: b = a;
            2: a = 16'h8000;
            3: b = 16'hFFFF;
            default: ;
         endcase
         sh  = 4'($urandom_range(0, 15));
         exp = model(op, a, b, sh, mflags);
         do_op(100 + i, op, a, b, 3'($urandom_range(0, 7)), sh, $urandom_range(0, 2),
               exp[19:4], exp[3:0]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
